// File: rtl/decoder_arb.sv
// Round-robin arbiter sharing one one-hot decoder among NREQ requesters via a two-stage pipeline.
// Optional feature: define DECODER_ARB_CHECK_EN to build the sticky decode-check comparator on err.
module decoder_arb #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned AW   = 5,
  parameter int unsigned IDW  = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NREQ-1:0]        req_valid,
  input  logic [NREQ*AW-1:0]     req_addr,
  output logic [NREQ-1:0]        req_ready,
  output logic [AW-1:0]          dec_a,
  input  logic [(2**AW)-1:0]     dec_z,
  output logic                   out_valid,
  output logic [(2**AW)-1:0]     out_z,
  output logic [IDW-1:0]         out_id,
  input  logic                   out_ready,
  output logic                   err
);

  localparam int unsigned ZW = 2**AW;

  logic            s1_valid;
  logic [AW-1:0]   s1_addr;
  logic [IDW-1:0]  s1_id;
  logic [IDW-1:0]  last;

  logic            s2_free;
  logic            s1_free;
  logic            s2_load;
  logic            accept;
  logic            grant_found;
  logic [IDW-1:0]  grant;
  logic [IDW-1:0]  idx;
  logic [AW-1:0]   grant_addr;

  assign s2_free = !out_valid || out_ready;
  assign s1_free = !s1_valid || s2_free;
  assign s2_load = s1_valid && s2_free;
  assign accept  = rst_n && grant_found && s1_free;
  assign dec_a   = s1_addr;

  // Rotating-priority search starting just after the last accepted requester.
  always_comb begin
    grant       = '0;
    grant_found = 1'b0;
    idx         = '0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      idx = IDW'((32'(last) + k) % NREQ);
      if (!grant_found && req_valid[idx]) begin
        grant_found = 1'b1;
        grant       = idx;
      end
    end
  end

  // Ready is masked during reset so no requester sees an accept in that cycle.
  always_comb begin
    req_ready = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      req_ready[i] = rst_n && grant_found && s1_free && (grant == IDW'(i));
    end
  end

  always_comb begin
    grant_addr = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (grant == IDW'(i)) begin
        grant_addr = req_addr[i*AW +: AW];
      end
    end
  end

  // Stage 1: accepted address feeds the decoder; priority rotates only on accept.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_addr  <= '0;
      s1_id    <= '0;
      last     <= IDW'(NREQ - 1);
    end else if (s1_free) begin
      s1_valid <= accept;
      if (accept) begin
        s1_addr <= grant_addr;
        s1_id   <= grant;
        last    <= grant;
      end
    end
  end

  // Stage 2: capture decoder output; reload in the same cycle as a drain.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_z     <= '0;
      out_id    <= '0;
    end else if (s2_load) begin
      out_valid <= 1'b1;
      out_z     <= dec_z;
      out_id    <= s1_id;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

`ifdef DECODER_ARB_CHECK_EN
  logic [ZW-1:0] z_expect;
  assign z_expect = ZW'(1) << s1_addr;

  // Sticky flag: any captured decode that is not the expected one-hot value.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err <= 1'b0;
    end else if (s2_load && (dec_z != z_expect)) begin
      err <= 1'b1;
    end
  end
`else
  assign err = 1'b0;
`endif

endmodule

// File: doc/decoder_arb.md
# decoder_arb

Round-robin arbiter that shares one 5-to-32 one-hot `decoder` instance among `NREQ` requesters. Each requester presents an address with a valid/ready handshake. The block grants one requester per cycle, drives the decoder's `A` input from a registered stage, and captures the decoder's `Z` output into an output register tagged with the requester id. It sits directly in front of the `decoder` and is its only driver.

## Interface
- `NREQ`, 4: number of requesters; legal range 2..8.
- `AW`, 5: decoder address width; the decoder output width is `2**AW`.
- `IDW`, 2: width of the requester id; must equal `clog2(NREQ)`.

Ports:
- `clk`  in  1  single clock; all state updates on its rising edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `req_valid`  in  NREQ  per-requester request valid.
- `req_addr`  in  NREQ*AW  per-requester address; requester i uses bits [i*AW +: AW].
- `req_ready`  out  NREQ  per-requester accept; at most one bit is high at a time.
- `dec_a`  out  AW  address to the decoder `A` input, driven from the stage-1 register.
- `dec_z`  in  2**AW  decoder `Z` output; combinational from `dec_a`.
- `out_valid`  out  1  output register holds a result.
- `out_z`  out  2**AW  captured one-hot decode.
- `out_id`  out  IDW  index of the requester that owns `out_z`.
- `out_ready`  in  1  downstream accept.
- `err`  out  1  sticky decode-check error (see Configuration).

## Operation
- The pipeline has two register stages:
  - S1: `s1_valid`, `s1_addr`, `s1_id`. `dec_a` = `s1_addr`.
  - S2: `out_valid`, `out_z`, `out_id`.
- Stall logic:
  - `s2_free` = !`out_valid` || `out_ready`.
  - `s1_free` = !`s1_valid` || `s2_free`.
- Arbitration:
  - Search `req_valid` starting at index `last+1` and wrapping modulo NREQ. The first set bit is the grant `g`.
  - `req_ready[g]` = `s1_free`. All other `req_ready` bits are 0.
  - When no `req_valid` bit is set, `req_ready` = 0.
- Accept: `req_valid[g]` && `req_ready[g]`. On an accept, S1 loads `req_addr[g]` and `g`, `s1_valid` = 1, and `last` <= `g`.
- When S1 is free but nothing is accepted, `s1_valid` <= 0.
- When S1 holds data and `s2_free` = 1, S2 loads `dec_z` and `s1_id`, and `out_valid` = 1.
- When `out_valid` && `out_ready` and S1 is empty, `out_valid` <= 0.
- Under simultaneous S2 drain and S1 advance, S2 reloads in the same cycle with no bubble.
- `last` changes only on an accept. A stalled grant does not rotate priority.
- A requester must hold `req_valid` and `req_addr` stable until accepted. The arbiter does not check this.
- Reset values (applied when `rst_n` = 0 at a rising edge):
  - `s1_valid` = 0, `s1_addr` = 0, `s1_id` = 0.
  - `out_valid` = 0, `out_z` = 0, `out_id` = 0.
  - `err` = 0.
  - `last` = NREQ-1, so requester 0 has first priority.
  - `req_ready` reads 0 for the whole reset cycle.
- Reset mid-operation discards the in-flight S1 and S2 contents with no output handshake. Requesters do not see a spurious accept.

## Timing
- Latency: a request accepted at edge T gives `dec_a` valid after T. `out_valid`, `out_z` and `out_id` are valid after edge T+1, i.e. 2 edges from accept to output.
- Throughput: 1 decode per cycle while `out_ready` = 1.
- Backpressure: when `out_ready` = 0 with both stages full, all `req_ready` = 0. `out_*` and `dec_a` hold.
- `req_ready` is combinational from `req_valid`, `out_ready`, `out_valid`, `s1_valid` and `last`. It has no path from `req_addr`.
- The `dec_z` to `out_z` path must fit the decoder delay plus register setup inside one `CLOCK_PERIOD`.

## Configuration
- Macro: `DECODER_ARB_CHECK_EN`.
- Defined:
  - S2 compares the captured `dec_z` against `1 << s1_addr` on every S2 load.
  - On a mismatch, `err` <= 1 and stays 1 until reset. Data still flows unmodified.
- Undefined:
  - The comparator is not built and `err` is tied to 0.
  - The port list is identical in both builds.

## Test plan
- Single requester: reset, then requester 2 sends addr 5 with `out_ready` = 1. Required: `req_ready[2]` is high in the same cycle, and 2 edges later `out_valid` = 1, `out_z` = 32'h0000_0020, `out_id` = 2.
- All four requesters valid continuously with addrs 0,1,2,3 and `out_ready` = 1. Required: grants are 0,1,2,3,0,… and `out_z` = 1,2,4,8,1,… back to back.
- Backpressure: 3 accepts, then `out_ready` = 0 for 4 cycles. Required: `req_ready` = 0 and `out_z`/`out_id` held for those 4 cycles. On release, the remaining results drain in order with no loss or duplication, and the next grant continues from `last`+1.
- Sweep: requester 0 sends addr 0..31 sequentially. Required: `out_z` == 1 << i for every i, and `err` = 0 with the macro defined.
- Reset mid-flight: assert `rst_n` = 0 for one cycle while both stages are full. Required: next cycle `out_valid` = 0, `out_z` = 0, and requester 0 wins the first arbitration after reset.
- With `DECODER_ARB_CHECK_EN`: force `dec_z` = 0 for one S2 load. Required: `err` rises after that edge and stays 1 until `rst_n` = 0.
